dmem_responder: RTL and testbench

- Data-memory responder (slave) for the CPU's MEM-stage load/store initiator, replacing the zero-wait internal data array with a handshaked, multi-cycle memory.
- Accepts one word access at a time, models LATENCY wait cycles, then returns a one-cycle response.
- Drives a stall line back to the pipeline so IF/ID/EX/MEM registers hold while an access is outstanding.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/dmem_array.sv | 43 ++++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and FSM encoding for the data-memory responder
// Contents:
//   WORD_W          data word width
//   DEFAULT_LATENCY default wait cycles between accept and access
//   DEFAULT_ADDR_W  default word-index width of the data array
//   dmem_state_e    responder FSM encoding (IDLE/BUSY/DONE)
package cpu_pkg;

    localparam int WORD_W          = 32;
    localparam int DEFAULT_LATENCY = 2;
    localparam int DEFAULT_ADDR_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous single-port word RAM with registered read data
// Ports:
//   clk    clock
//   rst    asynchronous active-low reset (clears only the read register)
//   we     write enable: mem[addr] <= wdata
//   re     read enable: rdata <= mem[addr]; rdata holds otherwise
//   addr   word index
//   wdata  write data
//   rdata  registered read data
module dmem_array
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage is deliberately not reset so contents survive a reset.
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked multi-cycle data-memory responder for the MEM stage
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (accepted on valid & ready edge)
//   req_write           1 = store, 0 = load
//   req_addr            byte address; upper bits alias
//   req_wdata           store data
//   stall               pipeline freeze while an access is outstanding
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           load data, holds its last value
//   rsp_err             misaligned access, qualified by rsp_valid
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e        state_q;
    dmem_state_e        state_d;
    logic [3:0]         cnt_q;
    logic               cap_write;
    logic [ADDR_W+1:0]  cap_addr;
    logic [WORD_W-1:0]  cap_wdata;
    logic               access;
    logic               aligned;
    logic               mem_we;
    logic               mem_re;

    // Address bits above the array size alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // The captured transaction completes even if req_valid drops.
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                cap_write <= req_write;
                cap_addr  <= req_addr[ADDR_W+1:0];
                cap_wdata <= req_wdata;
                cnt_q     <= CNT_INIT;
            end else if (state_q == ST_BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign aligned = (cap_addr[1:0] == 2'b00);
    assign mem_we  = access & cap_write & aligned;
    assign mem_re  = access & ~cap_write & aligned;

    dmem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .addr (cap_addr[ADDR_W+1:2]),
        .wdata(cap_wdata),
        .rdata(rsp_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_err   = (state_q == ST_DONE) & ~aligned;
    assign stall     = req_valid & (state_q != ST_DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [DEPTH];
    bit          known [DEPTH];
    logic [31:0] last_rdata;
    bit          last_known;

    dmem_responder #(
        .ADDR_W (AW),
        .LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .stall    (stall),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    // One complete transaction; optionally drops req_valid after the first BUSY cycle.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input bit drop);
        int          stall_cnt;
        int          cyc;
        bit          got;
        bit          exp_err;
        logic [31:0] exp_rd;
        bit          rd_known;
        @(negedge clk);
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        #1;
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        stall_cnt = stall ? 1 : 0;
        @(negedge clk);
        cyc = 1;
        got = 0;
        check("ready_after_accept", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (stall) stall_cnt++;
            if (drop) req_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("rsp_seen", {31'd0, got}, 32'd1);
        exp_err  = (addr[1:0] != 2'b00);
        exp_rd   = last_rdata;
        rd_known = last_known;
        if (!exp_err) begin
            if (wr) begin
                mem_m[widx(addr)] = wd;
                known[widx(addr)] = 1'b1;
            end else begin
                exp_rd   = mem_m[widx(addr)];
                rd_known = known[widx(addr)];
            end
        end
        if (got) begin
            check("latency", cyc, LAT + 1);
            if (!drop) check("stall_cycles", stall_cnt, LAT + 1);
            check("stall_in_done", {31'd0, stall}, 32'd0);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            if (rd_known) check("rsp_rdata", rsp_rdata, exp_rd);
        end
        last_rdata = exp_rd;
        last_known = rd_known;
        req_valid  = 1'b0;
        @(negedge clk);
        check("rsp_one_pulse", {31'd0, rsp_valid}, 32'd0);
        check("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        last_rdata = 32'd0;
        last_known = 1'b1;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b0);
        access(1'b1, 32'h14, 32'h1, 1'b0);
        access(1'b0, 32'h14, 32'h0, 1'b0);
        access(1'b1, 32'h13, 32'h12345678, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b0);
        access(1'b1, 32'h404, 32'hA5A5A5A5, 1'b0);
        access(1'b0, 32'h004, 32'h0, 1'b0);

        // Reset during BUSY of a store: store must not commit.
        access(1'b1, 32'h20, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_rdata", rsp_rdata, 32'd0);
        check("midrst_err", {31'd0, rsp_err}, 32'd0);
        req_valid = 1'b0;
        #1;
        check("midrst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        last_rdata = 32'd0;
        last_known = 1'b1;
        access(1'b0, 32'h20, 32'h0, 1'b0);

        // req_valid dropped while BUSY: store still commits.
        access(1'b1, 32'h30, 32'h55, 1'b1);
        access(1'b0, 32'h30, 32'h0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int          r;
            int          idx;
            bit          wr;
            logic [31:0] a;
            r   = int'($urandom_range(0, 3));
            idx = int'($urandom_range(0, 15));
            a   = (32'(idx) << 2) | (32'($urandom_range(0, 3)) << (AW + 2));
            if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
            wr = (r >= 2) || !known[idx];
            access(wr, a, $urandom, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
